// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: credit-limited sequential word fetch into an in-order
// prefetch FIFO, valid/ready delivery to decode, and wrong-path discard on redirect.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   live_q, live_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;

  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];

  logic [CW+1:0]   credit_used;
  logic            grant;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;
  logic            unused_pc_bits;

  // FIFO slots plus every outstanding response (live or to-be-dropped) share DEPTH credits
  assign credit_used = {2'b00, count_q} + {2'b00, live_q} + {2'b00, disc_q};

  assign imem_req_o  = ~rst_i & ~redirect_i & (credit_used < (CW+2)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign grant = imem_req_o & imem_gnt_i;
  assign push  = imem_rvalid_i & (disc_q == '0) & ~redirect_i;
  assign pop   = instr_valid_o & instr_ready_i & ~redirect_i;

  assign target_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : '0;

  always_comb begin
    count_d    = count_q;
    live_d     = live_q;
    disc_d     = disc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;

    if (redirect_i) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything still outstanding becomes wrong-path; a response arriving now is dropped here
      disc_d     = disc_q + live_q + CW'(grant) - CW'(imem_rvalid_i);
      live_d     = '0;
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rvalid_i) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + XLEN'(4);
        end
      end
      live_d  = live_q + CW'(grant) - CW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      live_q     <= '0;
      disc_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else begin
      count_q    <= count_d;
      live_q     <= live_d;
      disc_q     <= disc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: memory responder with epoch-tagged requests
// and a queue-level model of what decode must see, plus directed scenarios.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int epoch; int rdy; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t pend[$];    // granted requests the memory still owes a response for
  ent_t mq[$];      // instructions decode must see, in order
  logic [31:0] mfetch = RESET_PC;
  int epoch = 0;
  int cyc = 0;

  int checks = 0;
  int errors = 0;

  int gnt_pct = 100, rv_pct = 100, ready_pct = 100, redir_pct = 0;
  bit force_redir = 0;
  logic [31:0] force_pc = '0;

  logic obs_req, obs_gnt, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic exp_req;
    logic rv_now;
    req_t r;
    imem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    rv_now = 1'b0;
    if (pend.size() > 0) begin
      if (pend[0].rdy <= cyc && $urandom_range(0, 99) < rv_pct) rv_now = 1'b1;
    end
    imem_rvalid_i = rv_now;
    imem_rdata_i  = rv_now ? (pend[0].addr ^ XORK) : 32'hDEAD_BEEF;
    instr_ready_i = ($urandom_range(0, 99) < ready_pct);
    if (force_redir) begin
      redirect_i = 1'b1;
      redirect_pc_i = force_pc;
      force_redir = 0;
    end else begin
      redirect_i = ($urandom_range(0, 99) < redir_pct);
      redirect_pc_i = $urandom & 32'h0000_0FFF;
    end

    @(negedge clk_i);
    exp_req = !redirect_i && ((mq.size() + pend.size()) < DEPTH);
    obs_req = imem_req_o; obs_addr = imem_addr_o; obs_gnt = imem_gnt_i;
    obs_valid = instr_valid_o; obs_pc = instr_pc_o; obs_instr = instr_o;
    chk("req", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (exp_req) chk("addr", imem_addr_o, mfetch);
    chk("valid", {31'b0, instr_valid_o}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("instr", instr_o, mq[0].data);
      chk("instr_pc", instr_pc_o, mq[0].pc);
    end

    @(posedge clk_i);
    if (rv_now) r = pend.pop_front();
    if (redirect_i) begin
      mq.delete();
      epoch++;
      mfetch = redirect_pc_i & ~32'h3;
    end else begin
      if (mq.size() > 0 && instr_ready_i) void'(mq.pop_front());
      if (rv_now && r.epoch == epoch) mq.push_back('{r.addr, r.addr ^ XORK});
      if (exp_req && imem_gnt_i) begin
        pend.push_back('{mfetch, epoch, cyc + 1});
        mfetch = mfetch + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_i = 1'b1;
    redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
    mq.delete(); pend.delete();
    mfetch = RESET_PC;
    epoch++;
    @(posedge clk_i); @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic wait_first_valid(input string nm, input logic [31:0] exp);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (obs_valid) begin
        seen = 1;
        chk(nm, obs_pc, exp);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no valid expected pc %h", nm, exp);
    end
  endtask

  initial begin
    int g;
    @(posedge clk_i); #1;

    // 1: streaming, first decode at grant+2
    do_reset();
    gnt_pct = 100; rv_pct = 100; ready_pct = 100; redir_pct = 0;
    step(); chk("t1_addr0", obs_addr, 32'h0); chk("t1_req0", {31'b0, obs_req}, 32'd1);
    step(); chk("t1_addr1", obs_addr, 32'h4); chk("t1_noval", {31'b0, obs_valid}, 32'd0);
    step(); chk("t1_pc0", obs_pc, 32'h0); chk("t1_data0", obs_instr, 32'hA5A5_0000);
    step(); chk("t1_pc1", obs_pc, 32'h4); chk("t1_data1", obs_instr, 32'hA5A5_0004);

    // 2: decode stalled fills exactly DEPTH credits
    do_reset();
    ready_pct = 0; g = 0;
    repeat (8) begin step(); if (obs_req && obs_gnt) g++; end
    chk("t2_grants", g, 32'd4); chk("t2_req_off", {31'b0, obs_req}, 32'd0);
    ready_pct = 100; step();
    ready_pct = 0; g = 0;
    step(); chk("t2_addr10", obs_addr, 32'h10); if (obs_req && obs_gnt) g++;
    repeat (3) begin step(); if (obs_req && obs_gnt) g++; end
    chk("t2_one_more", g, 32'd1);

    // 3: request held without grant
    do_reset();
    ready_pct = 100; gnt_pct = 100;
    step(); step();
    gnt_pct = 0;
    repeat (3) begin step(); chk("t3_hold_addr", obs_addr, 32'h8); chk("t3_hold_req", {31'b0, obs_req}, 32'd1); end
    gnt_pct = 100;
    step(); chk("t3_gnt_addr", obs_addr, 32'h8);
    step(); chk("t3_next_addr", obs_addr, 32'hC);

    // 4: redirect with 0x4/0x8 in flight
    do_reset();
    rv_pct = 0; step();
    rv_pct = 100; step();
    rv_pct = 0; step();
    force_redir = 1; force_pc = 32'h100;
    step(); chk("t4_no_req", {31'b0, obs_req}, 32'd0);
    rv_pct = 100;
    step(); chk("t4_addr", obs_addr, 32'h100); chk("t4_empty", {31'b0, obs_valid}, 32'd0);
    wait_first_valid("t4_first_pc", 32'h100);

    // 5: redirect coinciding with rvalid, grant and pop, three responses outstanding
    do_reset();
    rv_pct = 0; step(); step(); step();
    rv_pct = 100; step();
    force_redir = 1; force_pc = 32'h300;
    step(); chk("t5_valid_at_redir", {31'b0, obs_valid}, 32'd1);
    wait_first_valid("t5_first_pc", 32'h300);

    // 6: low target bits ignored
    repeat (3) step();
    force_redir = 1; force_pc = 32'h0000_0202;
    step();
    step(); chk("t6_addr", obs_addr, 32'h200);
    wait_first_valid("t6_first_pc", 32'h200);

    // random traffic, with one asynchronous reset in the middle
    for (int seg = 0; seg < 5; seg++) begin
      gnt_pct = $urandom_range(30, 100);
      rv_pct = $urandom_range(30, 100);
      ready_pct = $urandom_range(20, 100);
      redir_pct = $urandom_range(1, 6);
      repeat (600) step();
      if (seg == 2) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
